// File: rtl/rf_wport_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf_wport_arbiter_pkg
//   Shared constants and types for the register-file write-port arbiter.
//   - RFARB_ADDR_WIDTH / RFARB_DATA_WIDTH : regfile address and data widths
//   - RFARB_ENTRY_WIDTH                   : one queued LU result {waddr, wdata}
//   - RFARB_DEFAULT_DEPTH                 : default long-latency FIFO depth
//   - RFARB_DEFAULT_STARVE_LIMIT          : default starvation threshold
// -----------------------------------------------------------------------------
package rf_wport_arbiter_pkg;

  localparam int RFARB_ADDR_WIDTH           = 5;
  localparam int RFARB_DATA_WIDTH           = 32;
  localparam int RFARB_ENTRY_WIDTH          = RFARB_ADDR_WIDTH + RFARB_DATA_WIDTH;
  localparam int RFARB_DEFAULT_DEPTH        = 2;
  localparam int RFARB_DEFAULT_STARVE_LIMIT = 4;

  // Packed so that {waddr, wdata} occupies exactly RFARB_ENTRY_WIDTH bits.
  typedef struct packed {
    logic [RFARB_ADDR_WIDTH-1:0] waddr;
    logic [RFARB_DATA_WIDTH-1:0] wdata;
  } rfarb_entry_t;

  // Register 0 is hard-wired; any write targeting it must not reach the regfile.
  function automatic logic rfarb_addr_writes(input logic [RFARB_ADDR_WIDTH-1:0] addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/rf_wport_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// rfarb_fifo
//   DEPTH x RFARB_ENTRY_WIDTH FIFO holding long-latency results waiting for
//   a free regfile write slot. Storage is plain registers because every entry
//   is visible at once for the forwarding search.
//   Ports:
//     clk, reset        : clock, synchronous active-high reset
//     push_i            : store push_entry_i (ignored when full)
//     push_entry_i      : entry to store
//     pop_i             : drop the head entry (ignored when empty)
//     full_o, empty_o   : occupancy flags (registered state only)
//     head_o            : oldest entry
//     entry_vld_o       : per-slot valid bits
//     entries_o         : all slots, flattened, slot i at [i*W +: W]
//     rd_ptr_o          : slot index of the head, used to order the search
// -----------------------------------------------------------------------------
module rfarb_fifo
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = RFARB_DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push_i,
  input  rfarb_entry_t                       push_entry_i,
  input  logic                               pop_i,
  output logic                               full_o,
  output logic                               empty_o,
  output rfarb_entry_t                       head_o,
  output logic [DEPTH-1:0]                   entry_vld_o,
  output logic [DEPTH*RFARB_ENTRY_WIDTH-1:0] entries_o,
  output logic [PTR_W-1:0]                   rd_ptr_o
);

  // One extra count bit separates full from empty when the pointers coincide.
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  rfarb_entry_t     slot_arr [DEPTH];

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // A push is refused when full even if a pop frees a slot this same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      rfarb_entry_t mem_q;
      logic         vld_q;

      // Data needs no reset: the valid bit gates every consumer.
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
          mem_q <= push_entry_i;
        end
      end

      // Push and pop never hit the same slot in one cycle: that would need
      // wr_ptr==rd_ptr while non-full, i.e. empty, and then no pop happens.
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q <= 1'b0;
        end else if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
          vld_q <= 1'b1;
        end else if (do_pop && (rd_ptr_q == PTR_W'(gi))) begin
          vld_q <= 1'b0;
        end
      end

      assign slot_arr[gi]                                        = mem_q;
      assign entry_vld_o[gi]                                     = vld_q;
      assign entries_o[gi*RFARB_ENTRY_WIDTH +: RFARB_ENTRY_WIDTH] = mem_q;
    end
  endgenerate

  assign head_o   = slot_arr[rd_ptr_q];
  assign rd_ptr_o = rd_ptr_q;

endmodule

// File: rtl/rf_wport_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wport_arbiter
//   Shares the single regfile write port between in-order pipeline writeback
//   (WB) and the long-latency unit (LU). LU results queue in a small FIFO and
//   drain whenever WB leaves the port idle; a starvation counter forces one
//   FIFO grant (stalling WB one cycle) after STARVE_LIMIT lost cycles.
//   Optional build macro: RFARB_FWD_EN enables the FIFO forwarding search.
//   Ports:
//     clk, reset                       : clock, synchronous active-high reset
//     wb_valid/wb_waddr/wb_wdata       : pipeline writeback request
//     wb_ready                         : WB write accepted (WB ready_go)
//     lu_valid/lu_waddr/lu_wdata       : long-latency result
//     lu_ready                         : FIFO can accept (not full)
//     rf_we/rf_waddr/rf_wdata          : regfile write port
//     busy                             : FIFO non-empty
//     fwd_raddr/fwd_hit/fwd_data       : forwarding lookup into the FIFO
// -----------------------------------------------------------------------------
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH        = RFARB_DEFAULT_DEPTH,
  parameter int STARVE_LIMIT = RFARB_DEFAULT_STARVE_LIMIT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wb_valid,
  input  logic [RFARB_ADDR_WIDTH-1:0] wb_waddr,
  input  logic [RFARB_DATA_WIDTH-1:0] wb_wdata,
  output logic                        wb_ready,
  input  logic                        lu_valid,
  input  logic [RFARB_ADDR_WIDTH-1:0] lu_waddr,
  input  logic [RFARB_DATA_WIDTH-1:0] lu_wdata,
  output logic                        lu_ready,
  output logic                        rf_we,
  output logic [RFARB_ADDR_WIDTH-1:0] rf_waddr,
  output logic [RFARB_DATA_WIDTH-1:0] rf_wdata,
  output logic                        busy,
  input  logic [RFARB_ADDR_WIDTH-1:0] fwd_raddr,
  output logic                        fwd_hit,
  output logic [RFARB_DATA_WIDTH-1:0] fwd_data
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam int              SC_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] LIMIT_C = SC_W'(STARVE_LIMIT);

  logic                               fifo_full, fifo_empty;
  rfarb_entry_t                       fifo_head;
  rfarb_entry_t                       push_entry;
  logic [DEPTH-1:0]                   entry_vld;
  logic [DEPTH*RFARB_ENTRY_WIDTH-1:0] entries_flat;
  logic [PTR_W-1:0]                   rd_ptr;
  logic                               push, pop;
  logic                               pending, force_grant, wb_win;
  logic [SC_W-1:0]                    starve_q, starve_d;

  assign pending = !fifo_empty;

  // lu_ready depends on registered occupancy only, never on wb_valid.
  assign lu_ready = !reset && !fifo_full;

  // r0 results are acknowledged but dropped instead of occupying a slot.
  assign push       = lu_valid && lu_ready && rfarb_addr_writes(lu_waddr);
  assign push_entry = '{waddr: lu_waddr, wdata: lu_wdata};

  // Grant: WB unless the FIFO has starved long enough; otherwise the head.
  assign force_grant = pending && (starve_q == LIMIT_C);
  assign wb_win      = !reset && wb_valid && !force_grant;
  assign pop         = !reset && !wb_win && pending;

  // An idle pipeline sees ready even when no write happens.
  assign wb_ready = !reset && (wb_win || !pending);
  assign busy     = !reset && pending;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (wb_win) begin
      rf_we    = rfarb_addr_writes(wb_waddr);
      rf_waddr = wb_waddr;
      rf_wdata = wb_wdata;
    end else if (pop) begin
      rf_we    = rfarb_addr_writes(fifo_head.waddr);
      rf_waddr = fifo_head.waddr;
      rf_wdata = fifo_head.wdata;
    end
  end

  // Counts cycles the queued head lost to WB; saturating at the limit is
  // what raises force_grant, and the resulting pop clears it again.
  always_comb begin
    starve_d = starve_q;
    if (pop || !pending) begin
      starve_d = '0;
    end else if (wb_win && (starve_q != LIMIT_C)) begin
      starve_d = starve_q + SC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  rfarb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_o       (fifo_head),
    .entry_vld_o  (entry_vld),
    .entries_o    (entries_flat),
    .rd_ptr_o     (rd_ptr)
  );

`ifdef RFARB_FWD_EN
  rfarb_entry_t fwd_ent [DEPTH];
  logic         fwd_hit_c;
  logic [RFARB_DATA_WIDTH-1:0] fwd_data_c;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd_unpack
      assign fwd_ent[gi] = entries_flat[gi*RFARB_ENTRY_WIDTH +: RFARB_ENTRY_WIDTH];
    end
  endgenerate

  // Walk slots oldest to youngest starting at the head, so the last match
  // seen is the youngest. Only state from the start of the cycle is searched.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    idx        = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (entry_vld[idx] && (fwd_ent[idx].waddr == fwd_raddr)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = fwd_ent[idx].wdata;
      end
    end
  end

  assign fwd_hit  = !reset && fwd_hit_c && rfarb_addr_writes(fwd_raddr);
  assign fwd_data = fwd_data_c;
`else
  // Forwarding disabled: no compare logic, the lookup inputs are sunk here.
  logic unused_fwd;
  assign unused_fwd = ^{fwd_raddr, entry_vld, entries_flat, rd_ptr};
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wport_arbiter
//   Table of single-cycle vectors plus hand-written multi-cycle sequences
//   (starvation, fill, forwarding, reset mid-drain). Expected LU writes go
//   into a queue when accepted and are popped when the regfile port shows a
//   FIFO grant; WB grants are compared against the driven WB request.
// -----------------------------------------------------------------------------
module tb_rf_wport_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_ready;
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
  logic [4:0]  fwd_raddr;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  int total = 0;
  int bad   = 0;

  logic [36:0] lu_q [$];

  typedef struct packed {
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        e_wbr;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_lur;
    logic        e_busy;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  rf_wport_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .wb_ready  (wb_ready),
    .lu_valid  (lu_valid),
    .lu_waddr  (lu_waddr),
    .lu_wdata  (lu_wdata),
    .lu_ready  (lu_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy),
    .fwd_raddr (fwd_raddr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    wb_valid = wv;
    wb_waddr = wa;
    wb_wdata = wd;
    lu_valid = lv;
    lu_waddr = la;
    lu_wdata = ld;
  endtask

  // Regfile port monitor: WB grants must mirror the WB request, FIFO grants
  // must match the oldest outstanding accepted LU result.
  logic mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en && rf_we) begin
      if (wb_ready) begin
        chk("wb_grant_valid", {31'd0, wb_valid}, 32'd1);
        chk("wb_grant_addr", {27'd0, rf_waddr}, {27'd0, wb_waddr});
        chk("wb_grant_data", rf_wdata, wb_wdata);
        $display("rf write WB  r%0d = %0h", rf_waddr, rf_wdata);
      end else if (lu_q.size() == 0) begin
        chk("lu_unexpected_write", {27'd0, rf_waddr}, 32'hFFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = lu_q.pop_front();
        chk("lu_grant_addr", {27'd0, rf_waddr}, {27'd0, e[36:32]});
        chk("lu_grant_data", rf_wdata, e[31:0]);
        $display("rf write LU  r%0d = %0h", rf_waddr, rf_wdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    reset     = 1'b1;
    fwd_raddr = 5'd0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    //                wv    wa     wd            lv    la     ld            wbr   we    ewa    ewd           lur   busy
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'h1234,     1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd5,  32'h1234,     1'b1, 1'b1};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h55,       1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
    vecs[6]  = '{1'b1, 5'd0,  32'h77,       1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
    vecs[7]  = '{1'b1, 5'd3,  32'hCAFE,     1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 5'd3,  32'hCAFE,     1'b1, 1'b0};
    vecs[8]  = '{1'b1, 5'd4,  32'h1,        1'b1, 5'd6,  32'h66,       1'b1, 1'b1, 5'd4,  32'h1,        1'b1, 1'b0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd6,  32'h66,       1'b1, 1'b1};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_ready", {31'd0, wb_ready}, 32'd0);
    chk("rst_lu_ready", {31'd0, lu_ready}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fwd_hit", {31'd0, fwd_hit}, 32'd0);
    $display("reset state checked");
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();

    // Table: idle, simple LU drain, r0 handling, WB writes
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].lv, vecs[i].la, vecs[i].ld);
      if (vecs[i].lv && vecs[i].la != 5'd0 && vecs[i].e_lur)
        lu_q.push_back({vecs[i].la, vecs[i].ld});
      #1;
      chk($sformatf("vec%0d_wb_ready", i), {31'd0, wb_ready}, {31'd0, vecs[i].e_wbr});
      chk($sformatf("vec%0d_rf_we", i), {31'd0, rf_we}, {31'd0, vecs[i].e_we});
      chk($sformatf("vec%0d_lu_ready", i), {31'd0, lu_ready}, {31'd0, vecs[i].e_lur});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
      if (vecs[i].e_we) begin
        chk($sformatf("vec%0d_rf_waddr", i), {27'd0, rf_waddr}, {27'd0, vecs[i].e_wa});
        chk($sformatf("vec%0d_rf_wdata", i), rf_wdata, vecs[i].e_wd);
      end
      $display("vec %0d wb_ready=%0b rf_we=%0b lu_ready=%0b busy=%0b", i, wb_ready, rf_we, lu_ready, busy);
      tick();
    end

    // Starvation: one queued entry, WB held busy; forced grant on 5th cycle
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd7, 32'h77AA);
    lu_q.push_back({5'd7, 32'h77AA});
    #1;
    chk("starve_push_wb_ready", {31'd0, wb_ready}, 32'd1);
    tick();
    lu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_wdata = 32'h101 + i;
      #1;
      chk($sformatf("starve_wb_grant%0d", i), {31'd0, wb_ready}, 32'd1);
      chk($sformatf("starve_busy%0d", i), {31'd0, busy}, 32'd1);
      $display("starve cycle %0d wb_ready=%0b", i, wb_ready);
      tick();
    end
    #1;
    chk("starve_forced_wb_ready", {31'd0, wb_ready}, 32'd0);
    chk("starve_forced_rf_we", {31'd0, rf_we}, 32'd1);
    chk("starve_forced_waddr", {27'd0, rf_waddr}, 32'd7);
    $display("starve forced grant wb_ready=%0b rf_waddr=%0d", wb_ready, rf_waddr);
    tick();
    #1;
    chk("starve_resume_wb_ready", {31'd0, wb_ready}, 32'd1);
    chk("starve_resume_busy", {31'd0, busy}, 32'd0);
    tick();

    // Fill: two pushes fill DEPTH=2, third is held until a forced pop frees a slot
    drive(1'b1, 5'd20, 32'h200, 1'b1, 5'd10, 32'hA0);
    #1;
    chk("fill_first_lu_ready", {31'd0, lu_ready}, 32'd1);
    lu_q.push_back({5'd10, 32'hA0});
    tick();
    lu_waddr = 5'd11;
    lu_wdata = 32'hB0;
    #1;
    chk("fill_second_lu_ready", {31'd0, lu_ready}, 32'd1);
    lu_q.push_back({5'd11, 32'hB0});
    tick();
    lu_waddr = 5'd12;
    lu_wdata = 32'hC0;
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (lu_ready) break;
      waits++;
      tick();
    end
    chk("fill_wait_cycles", waits, 32'd4);
    $display("fill third push waited %0d cycles", waits);
    lu_q.push_back({5'd12, 32'hC0});
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    waits = 0;
    while (busy && waits < 20) begin
      tick();
      waits++;
    end
    chk("fill_drain_busy", {31'd0, busy}, 32'd0);
    chk("fill_drain_queue", lu_q.size(), 32'd0);
    tick();

    // Forwarding: r9=0xA then r9=0xB queued behind WB traffic
    drive(1'b1, 5'd2, 32'h300, 1'b1, 5'd9, 32'hA);
    lu_q.push_back({5'd9, 32'hA});
    tick();
    lu_wdata  = 32'hB;
    fwd_raddr = 5'd9;
    lu_q.push_back({5'd9, 32'hB});
    #1;
`ifdef RFARB_FWD_EN
    chk("fwd_one_hit", {31'd0, fwd_hit}, 32'd1);
    chk("fwd_one_data", fwd_data, 32'hA);
`else
    chk("fwd_one_hit", {31'd0, fwd_hit}, 32'd0);
    chk("fwd_one_data", fwd_data, 32'h0);
`endif
    tick();
    lu_valid = 1'b0;
    #1;
`ifdef RFARB_FWD_EN
    chk("fwd_young_hit", {31'd0, fwd_hit}, 32'd1);
    chk("fwd_young_data", fwd_data, 32'hB);
`else
    chk("fwd_young_hit", {31'd0, fwd_hit}, 32'd0);
    chk("fwd_young_data", fwd_data, 32'h0);
`endif
    $display("fwd r9 hit=%0b data=%0h", fwd_hit, fwd_data);
    tick();
    fwd_raddr = 5'd0;
    #1;
    chk("fwd_r0_hit", {31'd0, fwd_hit}, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    waits = 0;
    while (busy && waits < 20) begin
      tick();
      waits++;
    end
    chk("fwd_drain_queue", lu_q.size(), 32'd0);
    tick();

    // Reset mid-drain discards the queued entry
    drive(1'b1, 5'd1, 32'h400, 1'b1, 5'd13, 32'hD0);
    tick();
    lu_valid = 1'b0;
    tick();
    reset    = 1'b1;
    wb_valid = 1'b0;
    lu_q.delete();
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_wb_ready", {31'd0, wb_ready}, 32'd0);
    chk("midrst_rf_we", {31'd0, rf_we}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("postrst_busy", {31'd0, busy}, 32'd0);
    chk("postrst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("postrst_wb_ready", {31'd0, wb_ready}, 32'd1);
    $display("reset mid-drain busy=%0b", busy);
    tick();
    tick();

    chk("final_queue_empty", lu_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
